// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message-schedule sigma functions.
package sha256_pkg;

  localparam int unsigned WordWidth = 32;

  typedef logic [WordWidth-1:0] word_t;

  // Rotate/shift amounts for sigma0 (W[t-15]) and sigma1 (W[t-2]).
  localparam int unsigned S0_R1 = 7;
  localparam int unsigned S0_R2 = 18;
  localparam int unsigned S0_SH = 3;
  localparam int unsigned S1_R1 = 17;
  localparam int unsigned S1_R2 = 19;
  localparam int unsigned S1_SH = 10;

  // 32-bit rotate right; only called with 0 < n < 32.
  function automatic word_t rotr32(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WordWidth - n));
  endfunction

endpackage

// File: rtl/sha256_sigma_comb.sv
// Combinational SHA-256 small sigma. SEL=0 selects sigma0, SEL=1 selects sigma1.
module sha256_sigma_comb
  import sha256_pkg::*;
#(
  parameter int unsigned SEL = 0
) (
  input  word_t x_i,
  output word_t s_o
);

  localparam int unsigned R1 = (SEL == 0) ? S0_R1 : S1_R1;
  localparam int unsigned R2 = (SEL == 0) ? S0_R2 : S1_R2;
  localparam int unsigned SH = (SEL == 0) ? S0_SH : S1_SH;

  if (SEL > 1) begin : gen_sel_check
    $error("sha256_sigma_comb: SEL must be 0 (sigma0) or 1 (sigma1)");
  end

  // Two rotates and a zero-filling shift, folded together with XOR.
  always_comb begin
    s_o = rotr32(x_i, R1) ^ rotr32(x_i, R2) ^ (x_i >> SH);
  end

endmodule

// File: rtl/sha256_small_sigma.sv
// SHA-256 message-schedule sigma0/sigma1 pair with optional output register stage.
// REG_OUT=1: one-cycle latency, data captured only on VALID_IN, sync active-high reset.
// REG_OUT=0: outputs follow the inputs combinationally and RST has no effect.
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter int unsigned REG_OUT = 1,
  parameter int unsigned WIDTH   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VALID_IN,
  input  logic [WIDTH-1:0] X0,
  input  logic [WIDTH-1:0] X1,
  output logic             VALID_OUT,
  output logic [WIDTH-1:0] S0,
  output logic [WIDTH-1:0] S1
);

  if (WIDTH != WordWidth) begin : gen_width_check
    $error("sha256_small_sigma: only WIDTH=32 is supported");
  end

  word_t s0_c, s1_c;
  word_t s0_d, s0_q;
  word_t s1_d, s1_q;
  logic  valid_q;

  sha256_sigma_comb #(
    .SEL (0)
  ) u_sigma0 (
    .x_i (X0),
    .s_o (s0_c)
  );

  sha256_sigma_comb #(
    .SEL (1)
  ) u_sigma1 (
    .x_i (X1),
    .s_o (s1_c)
  );

  // Data registers load only on a valid beat so idle (possibly X) inputs never reach them.
  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    if (VALID_IN) begin
      s0_d = s0_c;
      s1_d = s1_c;
    end
  end

  // Output stage; reset wins over a valid beat arriving in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_q    <= '0;
      s1_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      valid_q <= VALID_IN;
    end
  end

  // Constant select; synthesis drops the unused register stage when REG_OUT=0.
  always_comb begin
    if (REG_OUT != 0) begin
      S0        = s0_q;
      S1        = s1_q;
      VALID_OUT = valid_q;
    end else begin
      S0        = s0_c;
      S1        = s1_c;
      VALID_OUT = VALID_IN;
    end
  end

endmodule

// File: tb/tb_sha256_small_sigma.sv
// Scoreboard bench for sha256_small_sigma: registered and combinational instances share
// one stimulus stream; a negedge monitor checks each against a bit-level reference model.
module tb_sha256_small_sigma;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [31:0] x0, x1;

  logic        vo_r, vo_c;
  logic [31:0] s0_r, s1_r, s0_c, s1_c;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] s0;
    logic [31:0] s1;
    int          due;
  } exp_t;

  exp_t q_reg[$];
  exp_t q_comb[$];

  sha256_small_sigma #(
    .REG_OUT (1),
    .WIDTH   (32)
  ) dut_reg (
    .CLK       (clk),
    .RST       (rst),
    .VALID_IN  (valid_in),
    .X0        (x0),
    .X1        (x1),
    .VALID_OUT (vo_r),
    .S0        (s0_r),
    .S1        (s1_r)
  );

  sha256_small_sigma #(
    .REG_OUT (0),
    .WIDTH   (32)
  ) dut_comb (
    .CLK       (clk),
    .RST       (rst),
    .VALID_IN  (valid_in),
    .X0        (x0),
    .X1        (x1),
    .VALID_OUT (vo_c),
    .S0        (s0_c),
    .S1        (s1_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: each output bit is the XOR of the input bits the rotates/shift land on it.
  function automatic logic [31:0] ref_sigma(input logic [31:0] x, input int r1, input int r2,
                                            input int sh);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) begin
      y[i] = x[(i + r1) % 32] ^ x[(i + r2) % 32];
      if (i + sh < 32) y[i] = y[i] ^ x[i + sh];
    end
    return y;
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ref_sigma(x, 7, 18, 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ref_sigma(x, 17, 19, 10);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s at cycle %0d: got %08h, expected %08h", name, cyc, got, want);
  endtask

  // Drive one beat just after a rising edge and post the expected responses.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    valid_in = v;
    x0       = a;
    x1       = b;
    if (v) begin
      e.s0  = ref_s0(a);
      e.s1  = ref_s1(b);
      e.due = cyc;
      q_comb.push_back(e);
      if (!r) begin
        e.due = cyc + 1;
        q_reg.push_back(e);
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, $urandom, $urandom, 1'b0);
  endtask

  // Monitor: every cycle, each instance must be valid exactly when its queue front is due.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q_reg.size() > 0 && q_reg[0].due == cyc) begin
        e = q_reg.pop_front();
        check("reg_valid", {31'd0, vo_r}, 32'd1);
        check("reg_s0", s0_r, e.s0);
        check("reg_s1", s1_r, e.s1);
      end else begin
        check("reg_idle_valid", {31'd0, vo_r}, 32'd0);
      end
      if (q_comb.size() > 0 && q_comb[0].due == cyc) begin
        e = q_comb.pop_front();
        check("comb_valid", {31'd0, vo_c}, 32'd1);
        check("comb_s0", s0_c, e.s0);
        check("comb_s1", s1_c, e.s1);
      end else begin
        check("comb_idle_valid", {31'd0, vo_c}, 32'd0);
      end
    end
  end

  logic [31:0] vec[4];

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    x0       = '0;
    x1       = '0;

    // Reset for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s0", s0_r, 32'h0);
    check("rst_s1", s1_r, 32'h0);
    check("rst_valid", {31'd0, vo_r}, 32'd0);
    mon_en = 1'b1;

    // Idle after reset: everything stays zero.
    repeat (3) idle();
    @(negedge clk);
    check("idle_s0", s0_r, 32'h0);
    check("idle_s1", s1_r, 32'h0);

    // Known vectors, each followed by idle beats to exercise the data hold.
    vec[0] = 32'h0000_0001;
    vec[1] = 32'h8000_0000;
    vec[2] = 32'hFFFF_FFFF;
    vec[3] = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vec[i], vec[i], 1'b0);
      idle();
      idle();
      @(negedge clk);
      check("hold_s0", s0_r, ref_s0(vec[i]));
      check("hold_s1", s1_r, ref_s1(vec[i]));
    end
    // Hand-derived values cross-check the reference model itself.
    check("model_s0_one", ref_s0(32'h1), 32'h0200_4000);
    check("model_s1_one", ref_s1(32'h1), 32'h0000_A000);
    check("model_s0_msb", ref_s0(32'h8000_0000), 32'h1100_2000);
    check("model_s1_msb", ref_s1(32'h8000_0000), 32'h0020_5000);
    check("model_s0_ones", ref_s0(32'hFFFF_FFFF), 32'h1FFF_FFFF);
    check("model_s1_ones", ref_s1(32'hFFFF_FFFF), 32'h003F_FFFF);

    // All-ones immediately followed by zero.
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, 32'h0, 32'h0, 1'b0);
    idle();

    // Four back-to-back beats, then reset colliding with a fifth.
    for (int i = 0; i < 4; i++) drive(1'b1, $urandom, $urandom, 1'b0);
    drive(1'b1, $urandom, $urandom, 1'b1);
    idle();
    @(negedge clk);
    check("post_rst_s0", s0_r, 32'h0);
    check("post_rst_s1", s1_r, 32'h0);

    // Random traffic with occasional idle gaps.
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom, 1'b0);
    end
    repeat (3) idle();
    @(negedge clk);
    check("reg_queue_drained", q_reg.size(), 32'd0);
    check("comb_queue_drained", q_comb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
